// File: rtl/spi_man_tx_fifo.sv
// spi_man_tx_fifo: queues SPI words and launches one per Manchester frame slot as an enc_flag pulse
module spi_man_tx_fifo #(
    parameter int DW           = 16,
    parameter int AW           = 3,
    parameter int FRAME_CYCLES = 1200
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          rx_flag,
    input  logic [DW-1:0] rx_data,
    input  logic          clr_ovf,
    output logic          enc_flag,
    output logic [DW-1:0] enc_data,
    output logic [AW:0]   fifo_count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);
    localparam int DEPTH = 2 ** AW;
    localparam int GW    = $clog2(FRAME_CYCLES);

    typedef enum logic {IDLE, GAP} state_t;

    state_t        state, state_n;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap_cnt;
    logic          rx_flag_d;
    logic          push, pop, accept, drop;

    assign full   = fifo_count == (AW+1)'(DEPTH);
    assign empty  = fifo_count == '0;
    assign push   = rx_flag & ~rx_flag_d;
    assign pop    = (state == IDLE) & ~empty;
    // A pop in the same cycle frees the slot the incoming word lands in
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (empty ? IDLE : GAP) : ((gap_cnt == '0) ? IDLE : GAP);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk_in) begin
        if (accept) mem[wr_ptr] <= rx_data;
    end

    // rx_flag_d resets high so a level held through reset is not seen as an edge
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rx_flag_d  <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            gap_cnt    <= '0;
            enc_flag   <= 1'b0;
            enc_data   <= '0;
            overflow   <= 1'b0;
        end else begin
            rx_flag_d  <= rx_flag;
            enc_flag   <= pop;
            fifo_count <= fifo_count + (AW+1)'(accept) - (AW+1)'(pop);
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                enc_data <= mem[rd_ptr];
                gap_cnt  <= GW'(FRAME_CYCLES - 2);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_man_tx_fifo.sv
// tb_spi_man_tx_fifo: directed self-checking bench for spi_man_tx_fifo
module tb_spi_man_tx_fifo;
    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        rx_flag = 1'b0;
    logic [15:0] rx_data = '0;
    logic        clr_ovf = 1'b0;
    logic        enc_flag;
    logic [15:0] enc_data;
    logic [3:0]  fifo_count;
    logic        full, empty, overflow;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_launch = 0;

    spi_man_tx_fifo dut (
        .clk_in(clk_in), .rst(rst), .rx_flag(rx_flag), .rx_data(rx_data), .clr_ovf(clr_ovf),
        .enc_flag(enc_flag), .enc_data(enc_data), .fifo_count(fifo_count),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [15:0] d);
        rx_data = d;
        rx_flag = 1'b1;
        tick;
        rx_flag = 1'b0;
        tick;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic wait_launch(input string tag, input logic [15:0] d);
        for (int i = 0; i < 1300; i++) begin
            if (enc_flag === 1'b1) break;
            tick;
        end
        chk({tag, "_flag"}, enc_flag, 1);
        chk({tag, "_data"}, enc_data, d);
        last_launch = cyc;
    endtask

    initial begin
        int l0, highs;
        tick;
        chk("rst_flag", enc_flag, 0);
        chk("rst_data", enc_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick;

        // single word
        rx_data = 16'hA5C3;
        rx_flag = 1'b1;
        tick;
        chk("t1_count1", fifo_count, 1);
        chk("t1_noflag", enc_flag, 0);
        rx_flag = 1'b0;
        tick;
        chk("t1_flag", enc_flag, 1);
        chk("t1_data", enc_data, 16'hA5C3);
        chk("t1_count0", fifo_count, 0);
        chk("t1_empty", empty, 1);
        tick;
        chk("t1_pulse", enc_flag, 0);

        // burst of three, launches 1200 cycles apart
        reset_dut;
        push(16'h0001);
        wait_launch("t2_w1", 16'h0001);
        l0 = last_launch;
        push(16'h0002);
        push(16'h0003);
        chk("t2_pulse", enc_flag, 0);
        wait_launch("t2_w2", 16'h0002);
        chk("t2_gap12", last_launch - l0, 1200);
        l0 = last_launch;
        tick;
        wait_launch("t2_w3", 16'h0003);
        chk("t2_gap23", last_launch - l0, 1200);
        chk("t2_count", fifo_count, 0);

        // overflow while held in GAP
        reset_dut;
        push(16'h1001);
        wait_launch("t3_w1", 16'h1001);
        l0 = last_launch;
        for (int i = 2; i <= 10; i++) push(16'h1000 + 16'(i));
        chk("t3_count", fifo_count, 8);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow, 1);
        chk("t3_data", enc_data, 16'h1001);
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("t3_clr", overflow, 0);
        rx_data = 16'h100B;
        rx_flag = 1'b1;
        clr_ovf = 1'b1;
        tick;
        rx_flag = 1'b0;
        clr_ovf = 1'b0;
        chk("t3_drop_wins", overflow, 1);
        chk("t3_count2", fifo_count, 8);
        tick;
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        chk("t3_clr2", overflow, 0);

        // push lands on the exact pop edge from a full FIFO
        while (cyc < l0 + 1199) tick;
        rx_data = 16'h100C;
        rx_flag = 1'b1;
        tick;
        rx_flag = 1'b0;
        chk("t4_flag", enc_flag, 1);
        chk("t4_data", enc_data, 16'h1002);
        chk("t4_slot", cyc - l0, 1200);
        chk("t4_count", fifo_count, 8);
        chk("t4_full", full, 1);
        chk("t4_ovf", overflow, 0);
        for (int i = 3; i <= 9; i++) begin
            tick;
            wait_launch("t4_drain", 16'h1000 + 16'(i));
        end
        tick;
        wait_launch("t4_last", 16'h100C);
        tick;
        chk("t4_empty", empty, 1);

        // rx_flag held high through reset release
        rst = 1'b1;
        rx_flag = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        tick;
        chk("t5_nopush", fifo_count, 0);
        chk("t5_noflag", enc_flag, 0);
        rx_flag = 1'b0;
        tick;
        rx_data = 16'hBEEF;
        rx_flag = 1'b1;
        tick;
        chk("t5_count", fifo_count, 1);
        rx_flag = 1'b0;
        tick;
        chk("t5_flag", enc_flag, 1);
        chk("t5_data", enc_data, 16'hBEEF);
        l0 = cyc;

        // reset mid-gap with four words queued
        tick;
        for (int i = 0; i < 4; i++) push(16'h2000 + 16'(i));
        chk("t6_queued", fifo_count, 4);
        while (cyc < l0 + 300) tick;
        rst = 1'b1;
        #1;
        chk("t6_count", fifo_count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_data", enc_data, 0);
        chk("t6_flag", enc_flag, 0);
        chk("t6_ovf", overflow, 0);
        tick;
        tick;
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 2500; i++) begin
            tick;
            if (enc_flag === 1'b1) highs++;
        end
        chk("t6_silent", highs, 0);
        push(16'h5A5A);
        chk("t6_new_flag", enc_flag, 1);
        chk("t6_new_data", enc_data, 16'h5A5A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
